// File: rtl/bias_add_14.sv
// bias_add_14: merges the conv-14 accumulator stream with the per-channel
// bias stream, adds the aligned bias, optionally applies ReLU, rescales,
// saturates to DATA_WIDTH and pushes the result into the next FIFO.
module bias_add_14 #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_CH     = 32,
    parameter int PIXELS     = 64,
    parameter int BIAS_SHIFT = 8,
    parameter int OUT_SHIFT  = 8,
    parameter bit RELU       = 1'b1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [ACC_WIDTH-1:0]  acc_V_dout,
    input  logic                  acc_V_empty_n,
    output logic                  acc_V_read,
    input  logic [DATA_WIDTH-1:0] bias_V_dout,
    input  logic                  bias_V_empty_n,
    output logic                  bias_V_read,
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write,
    output logic                  frame_done
);
    // One extra bit keeps acc + aligned bias from ever wrapping.
    localparam int SW   = ACC_WIDTH + 1;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {S_BIAS, S_STREAM} state_t;

    state_t                       state;
    logic [CH_W-1:0]              ch_cnt;
    logic [PX_W-1:0]              pix_cnt;
    logic signed [DATA_WIDTH-1:0] bias_reg;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_valid;
    logic                         out_last;

    logic                         ok;
    logic                         xfer;
    logic                         last_ch;
    logic                         last_px;
    logic signed [SW-1:0]         acc_x;
    logic signed [SW-1:0]         bias_x;
    logic signed [SW-1:0]         sum;
    logic signed [SW-1:0]         sh;
    logic [DATA_WIDTH-1:0]        res;

    assign ok          = !out_valid | output_V_full_n;
    assign xfer        = out_valid & output_V_full_n;
    assign bias_V_read = (state == S_BIAS) & bias_V_empty_n;
    assign acc_V_read  = (state == S_STREAM) & acc_V_empty_n & ok;
    assign last_ch     = (ch_cnt == CH_W'(NUM_CH - 1));
    assign last_px     = (pix_cnt == PX_W'(PIXELS - 1));

    // Output side is purely registered; only frame_done looks at full_n.
    assign output_V_din   = out_data;
    assign output_V_write = out_valid;
    assign frame_done     = xfer & out_last;

    // Bias add, floor rescale, optional ReLU and saturation of the popped word.
    always_comb begin
        acc_x  = {acc_V_dout[ACC_WIDTH-1], acc_V_dout};
        bias_x = SW'(bias_reg) <<< BIAS_SHIFT;
        sum    = acc_x + bias_x;
        sh     = sum >>> OUT_SHIFT;
        if (RELU && (sh < 0))
            sh = '0;
        if (sh > SAT_MAX)
            res = SAT_MAX[DATA_WIDTH-1:0];
        else if (sh < SAT_MIN)
            res = SAT_MIN[DATA_WIDTH-1:0];
        else
            res = sh[DATA_WIDTH-1:0];
    end

    // Channel sequencing: one bias pop, then PIXELS accumulator pops.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= S_BIAS;
            ch_cnt   <= '0;
            pix_cnt  <= '0;
            bias_reg <= '0;
        end else begin
            case (state)
                S_BIAS: begin
                    if (bias_V_read) begin
                        bias_reg <= bias_V_dout;
                        pix_cnt  <= '0;
                        state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (acc_V_read) begin
                        if (last_px) begin
                            pix_cnt <= '0;
                            state   <= S_BIAS;
                            ch_cnt  <= last_ch ? '0 : ch_cnt + CH_W'(1);
                        end else begin
                            pix_cnt <= pix_cnt + PX_W'(1);
                        end
                    end
                end
                default: state <= S_BIAS;
            endcase
        end
    end

    // Output register: a pop reloads it (even while draining), a lone transfer empties it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (acc_V_read) begin
            out_data  <= res;
            out_valid <= 1'b1;
            out_last  <= last_ch & last_px;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bias_add_14.sv
// Bench for bias_add_14: two instances (RELU off/on) share one stimulus stream
// and are scored against a plain-arithmetic reference of the bias/rescale rules.
module tb_bias_add_14;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int C  = 3;
    localparam int P  = 4;
    localparam int BS = 8;
    localparam int OS = 8;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [AW-1:0] acc_dout = '0;
    logic          acc_empty_n = 1'b0;
    logic [DW-1:0] bias_dout = '0;
    logic          bias_empty_n = 1'b0;
    logic          full_n = 1'b1;

    logic          acc_rd_a, bias_rd_a, wr_a, fd_a;
    logic [DW-1:0] din_a;
    logic          acc_rd_b, bias_rd_b, wr_b, fd_b;
    logic [DW-1:0] din_b;

    int n_chk = 0;
    int n_err = 0;

    logic [AW-1:0] acc_q[$];
    logic [DW-1:0] bias_q[$];
    logic [DW:0]   exp_a[$];
    logic [DW:0]   exp_b[$];

    int            gen_ch = 0;
    int            acc_since = P;
    int            full_hold = 0;
    int            bias_wait = 0;
    int            cyc = 0;
    int            last_xfer = 0;
    bit            rand_mode = 1'b0;
    bit            gap_mode = 1'b0;
    bit [1:0]      stall = '0;
    logic [DW-1:0] held [2];

    always #5 ap_clk = ~ap_clk;

    bias_add_14 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_CH(C), .PIXELS(P),
                  .BIAS_SHIFT(BS), .OUT_SHIFT(OS), .RELU(1'b0)) dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .acc_V_dout(acc_dout), .acc_V_empty_n(acc_empty_n), .acc_V_read(acc_rd_a),
        .bias_V_dout(bias_dout), .bias_V_empty_n(bias_empty_n), .bias_V_read(bias_rd_a),
        .output_V_din(din_a), .output_V_full_n(full_n), .output_V_write(wr_a),
        .frame_done(fd_a));

    bias_add_14 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_CH(C), .PIXELS(P),
                  .BIAS_SHIFT(BS), .OUT_SHIFT(OS), .RELU(1'b1)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .acc_V_dout(acc_dout), .acc_V_empty_n(acc_empty_n), .acc_V_read(acc_rd_b),
        .bias_V_dout(bias_dout), .bias_V_empty_n(bias_empty_n), .bias_V_read(bias_rd_b),
        .output_V_din(din_b), .output_V_full_n(full_n), .output_V_write(wr_b),
        .frame_done(fd_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, floor shift, ReLU, clamp.
    function automatic logic [DW-1:0] ref_f(input logic signed [AW-1:0] a,
                                            input logic signed [DW-1:0] b, input bit relu);
        longint s, q, mx, mn;
        mx = (longint'(1) << (DW - 1)) - 1;
        mn = -mx - 1;
        s  = longint'(a) + longint'(b) * (longint'(1) << BS);
        q  = s >>> OS;
        if (relu && q < 0) q = 0;
        if (q > mx) q = mx;
        if (q < mn) q = mn;
        return q[DW-1:0];
    endfunction

    function automatic logic [AW-1:0] rnd_acc();
        if ($urandom_range(0, 3) == 0) return $urandom();
        return AW'($urandom_range(0, 1 << 20)) - AW'(1 << 19);
    endfunction

    function automatic logic [DW-1:0] rnd_bias();
        if ($urandom_range(0, 3) == 0) return DW'($urandom());
        return DW'($urandom_range(0, 1023)) - DW'(512);
    endfunction

    task automatic push_ch(input logic [DW-1:0] b, input logic [AW-1:0] a0, a1, a2, a3);
        logic [AW-1:0] a [4];
        logic          lst;
        a = '{a0, a1, a2, a3};
        bias_q.push_back(b);
        for (int p = 0; p < P; p++) begin
            lst = (gen_ch == C - 1) && (p == P - 1);
            acc_q.push_back(a[p]);
            exp_a.push_back({lst, ref_f(a[p], b, 1'b0)});
            exp_b.push_back({lst, ref_f(a[p], b, 1'b1)});
        end
        gen_ch = (gen_ch + 1) % C;
    endtask

    task automatic gen_random(input int frames);
        for (int i = 0; i < frames * C; i++)
            push_ch(rnd_bias(), rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
    endtask

    // One clock: drive upstream/downstream FIFO models, score outputs, pop inputs.
    task automatic step();
        logic          w, f;
        logic [DW-1:0] d;
        logic [DW:0]   e;
        @(negedge ap_clk);
        cyc++;
        if (full_hold > 0) begin
            full_n = 1'b0;
            full_hold--;
        end else if (rand_mode) begin
            full_n = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 30) == 0) full_hold = 5;
        end else begin
            full_n = 1'b1;
        end
        acc_empty_n  = (acc_q.size() > 0) && (!rand_mode || $urandom_range(0, 4) != 0);
        acc_dout     = (acc_q.size() > 0) ? acc_q[0] : '0;
        bias_empty_n = (bias_q.size() > 0) && (bias_wait == 0) &&
                       (!rand_mode || $urandom_range(0, 2) != 0);
        bias_dout    = (bias_q.size() > 0) ? bias_q[0] : '0;
        if (bias_wait > 0) bias_wait--;
        #1;
        for (int p = 0; p < 2; p++) begin
            w = (p == 0) ? wr_a : wr_b;
            d = (p == 0) ? din_a : din_b;
            f = (p == 0) ? fd_a : fd_b;
            if (stall[p]) begin
                chk("hold_write", w, 1);
                chk("hold_din", d, held[p]);
            end
            if (w && full_n) begin
                if (p == 0 && exp_a.size() == 0) chk("extra_word_relu0", 1, 0);
                else if (p == 1 && exp_b.size() == 0) chk("extra_word_relu1", 1, 0);
                else begin
                    if (p == 0) begin
                        e = exp_a.pop_front();
                        last_xfer = cyc;
                        chk("data_relu0", d, e[DW-1:0]);
                    end else begin
                        e = exp_b.pop_front();
                        chk("data_relu1", d, e[DW-1:0]);
                    end
                    chk("frame_done", f, e[DW]);
                end
            end else begin
                chk("frame_done_idle", f, 0);
            end
            stall[p] = w && !full_n;
            held[p]  = d;
        end
        if (wr_a && !full_n) chk("no_pop_stalled", acc_rd_a, 0);
        if (bias_rd_a) begin
            chk("bias_order", acc_since, P);
            acc_since = 0;
            if (bias_q.size() > 0) void'(bias_q.pop_front());
            if (gap_mode) bias_wait = 10;
        end
        if (acc_rd_a) begin
            chk("acc_order", acc_since < P, 1);
            chk("acc_rd_gate", acc_empty_n, 1);
            acc_since++;
            if (acc_q.size() > 0) void'(acc_q.pop_front());
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && n < max) begin
            step();
            n++;
        end
        chk("drain_timeout", exp_a.size() + exp_b.size(), 0);
    endtask

    initial begin
        int start;
        ap_rst_n = 1'b1;
        #1 ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        #1;
        chk("reset_write", wr_a, 0);
        chk("reset_din", din_a, 0);
        chk("reset_frame_done", fd_a, 0);
        chk("reset_acc_read", acc_rd_a, 0);
        chk("reset_bias_read", bias_rd_a, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Directed corner values: offsets, floor, ReLU, saturation both ways.
        push_ch(16'd3, 32'd0, 32'd256, -32'sd256, -32'sd1);
        push_ch(-16'sd10, 32'd0, 32'd2560, 32'h8000_0000, 32'd100);
        push_ch(16'h7FFF, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_0000, -32'sd8388352);
        push_ch(16'h8000, 32'h8000_0000, 32'd0, 32'd12345, -32'sd99999);
        push_ch(16'd0, -32'sd1, 32'd255, 32'd256, -32'sd257);
        push_ch(16'd1, -32'sd255, -32'sd256, 32'd7, 32'h7FFF_FFFF);
        drain(200);

        // Backpressure held mid-channel for 5 cycles.
        gen_random(1);
        repeat (4) step();
        full_hold = 5;
        drain(200);

        // Bias FIFO starved between channels, then fully random traffic.
        gap_mode = 1'b1;
        push_ch(16'd1, rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
        push_ch(16'd2, rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
        push_ch(16'd3, rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
        gen_random(2);
        drain(1000);
        gap_mode  = 1'b0;
        bias_wait = 0;
        rand_mode = 1'b1;
        gen_random(20);
        drain(4000);
        rand_mode = 1'b0;
        full_hold = 0;

        // Asynchronous reset in the middle of a channel.
        gen_random(1);
        repeat (3) step();
        @(posedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("midrst_write", wr_a, 0);
        chk("midrst_din", din_a, 0);
        chk("midrst_din_relu1", din_b, 0);
        chk("midrst_frame_done", fd_a, 0);
        chk("midrst_acc_read", acc_rd_a, 0);
        acc_q.delete();
        bias_q.delete();
        exp_a.delete();
        exp_b.delete();
        acc_empty_n  = 1'b0;
        bias_empty_n = 1'b0;
        stall        = '0;
        acc_since    = P;
        gen_ch       = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Full-rate streaming: one bubble per channel for the bias load.
        gen_random(2);
        start = cyc;
        drain(200);
        chk("throughput_last_cycle", last_xfer - start, 2 * C * (P + 1) + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
